// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the largest supported requester count.
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int NREQ_MAX = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts one position
// after the previous winner and wraps around, so the previous winner has the
// lowest priority.
// Ports:
//   req   in   NREQ  request vector
//   last  in   IDW   index of the previous winner
//   any   out  1     at least one request is set
//   idx   out  IDW   index of the winner (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   win;
    int                start;

    // Duplicating the request vector lets a plain right shift act as a
    // rotation, so bit 0 of win is the first candidate after last.
    always_comb begin
        start = (int'(last) + 1) % NREQ;
        dbl   = {req, req};
        win   = NREQ'(dbl >> start);
        any   = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit is the one left standing.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (win[k]) begin
                any = 1'b1;
                idx = IDW'((start + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-level round-robin arbiter sharing one FIFO write port among NREQ
// producers. A granted producer keeps the port until its last beat is
// accepted, so packets never interleave. Data path is purely combinational.
//
// Build option: define ARB_AFULL_GATE_EN to hold off new grants while
// fifo_afull=1 (a packet in progress always completes). Without it,
// fifo_afull is ignored.
//
// Ports:
//   clk         in   1        clock
//   rst         in   1        synchronous reset, active low
//   clr         in   1        synchronous flush, same effect as rst
//   req_valid   in   NREQ     per-requester beat valid
//   req_last    in   NREQ     per-requester last beat of packet
//   req_data    in   NREQ*DW  requester i data at [i*DW +: DW]
//   req_ready   out  NREQ     beat accepted when valid & ready
//   fifo_we     out  1        FIFO write enable
//   fifo_din    out  DW       FIFO write data
//   fifo_full   in   1        FIFO full
//   fifo_afull  in   1        FIFO almost full
//   gnt_id      out  IDW      current grant holder, valid while busy
//   busy        out  1        a grant is active
//
// States:
//   ST_IDLE  | no grant; waiting for a request (and an open gate)
//   ST_GRANT | gnt_id owns the write port until its last beat is accepted
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 fifo_we,
    output logic [DW-1:0]        fifo_din,
    input  logic                 fifo_full,
    input  logic                 fifo_afull,
    output logic [IDW-1:0]       gnt_id,
    output logic                 busy
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_gnt;
    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic            take;
    logic            gate_open;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            beat;
    logic            last_beat;

`ifdef ARB_AFULL_GATE_EN
    assign gate_open = !fifo_afull;
`else
    logic afull_unused;
    assign afull_unused = fifo_afull;
    assign gate_open    = 1'b1;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req_valid),
        .last (last_gnt),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Select the grant holder's signals by compare rather than variable
    // part-select so the index width never has to match NREQ exactly.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    assign busy      = (state == ST_GRANT);
    assign beat      = busy && sel_valid && !fifo_full;
    assign last_beat = beat && sel_last;

    always_comb begin
        req_ready = '0;
        fifo_we   = beat;
        fifo_din  = busy ? sel_data : '0;
        if (busy) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_id == IDW'(i)) begin
                    req_ready[i] = !fifo_full;
                end
            end
        end
    end

    // A new grant is taken from IDLE, or chained off the last beat so
    // back-to-back packets have no idle cycle between them.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any && gate_open) begin
                    state_nxt = ST_GRANT;
                    take      = 1'b1;
                end
            end
            ST_GRANT: begin
                if (last_beat) begin
                    if (pick_any && gate_open) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state    <= ST_IDLE;
            gnt_id   <= '0;
            last_gnt <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (take) begin
                gnt_id   <= pick_idx;
                last_gnt <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter: a reference model of the grant
// holder is compared against the DUT outputs every cycle, and the sequence of
// FIFO writes in each directed scenario is compared with literal values.
// Producer i emits data {i[1:0], seq[5:0]} with packets of len[i] beats.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                fifo_we;
    logic [DW-1:0]       fifo_din;
    logic                fifo_full;
    logic                fifo_afull;
    logic [IDW-1:0]      gnt_id;
    logic                busy;

    logic [NREQ-1:0]     en;
    logic [NREQ-1:0]     hold;
    int                  len [NREQ];
    int                  cnt [NREQ];
    int                  seq [NREQ];

    int                  n_chk  = 0;
    int                  n_fail = 0;

    int                  m_hold = -1;
    int                  m_last = NREQ - 1;
    int                  m_gid  = 0;
    int                  m_nxt;
    bit                  m_gate;

    logic [NREQ-1:0]     e_ready;
    logic                e_we;
    logic [DW-1:0]       e_din;
    logic [DW-1:0]       wlog [$];

    fifo_wr_arbiter #(
        .DW   (DW),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_afull (fifo_afull),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = en[i] & ~hold[i];
            req_last[i]           = (cnt[i] == len[i] - 1);
            req_data[i*DW +: DW]  = {2'(i), 6'(seq[i])};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester found walking forward from the previous winner.
    function automatic int rr_next(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: who holds the port after each clock edge.
    always @(posedge clk) begin
        if (!rst || clr) begin
            m_hold = -1;
            m_last = NREQ - 1;
            m_gid  = 0;
        end else begin
`ifdef ARB_AFULL_GATE_EN
            m_gate = !fifo_afull;
`else
            m_gate = 1'b1;
`endif
            m_nxt = rr_next(m_last, req_valid);
            if (m_hold < 0) begin
                if (m_nxt >= 0 && m_gate) begin
                    m_hold = m_nxt; m_last = m_nxt; m_gid = m_nxt;
                end
            end else if (req_valid[m_hold] && !fifo_full && req_last[m_hold]) begin
                if (m_nxt >= 0 && m_gate) begin
                    m_hold = m_nxt; m_last = m_nxt; m_gid = m_nxt;
                end else begin
                    m_hold = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        e_ready = '0;
        e_we    = 1'b0;
        e_din   = '0;
        if (m_hold >= 0) begin
            e_ready[m_hold] = !fifo_full;
            e_we            = req_valid[m_hold] & !fifo_full;
            e_din           = req_data[m_hold*DW +: DW];
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_we",   32'(fifo_we),   32'(e_we));
        chk("busy",      32'(busy),      32'(m_hold >= 0));
        chk("gnt_id",    32'(gnt_id),    32'(m_gid));
        if (e_we) chk("fifo_din", 32'(fifo_din), 32'(e_din));
        if (fifo_we) wlog.push_back(fifo_din);
    end

    task automatic cyc(input int n);
        logic [NREQ-1:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    cnt[i] = (cnt[i] + 1) % len[i];
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0; fifo_full = 1'b0; fifo_afull = 1'b0;
        en = '0; hold = '0;
        cyc(2);
        for (int i = 0; i < NREQ; i++) begin
            len[i] = 1; cnt[i] = 0; seq[i] = 0;
        end
        rst = 1'b1;
        wlog.delete();
    endtask

    // exp holds the n expected bytes, first write in the most significant byte.
    task automatic chk_log(input string nm, input int n, input logic [63:0] exp);
        chk({nm, "_count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk(nm, 32'(wlog[i]), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state, then two requesters with one-beat packets
        do_reset();
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_we",    32'(fifo_we),   32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_gnt",   32'(gnt_id),    32'd0);
        en = 4'b0101;
        cyc(5);
        chk_log("t1_rr", 4, 64'h00_80_01_81);

        // 2: three-beat packet from req1 is not interleaved with req3
        do_reset();
        len[1] = 3;
        en = 4'b1010;
        cyc(6);
        chk_log("t2_pkt", 5, 64'h40_41_42_C0_43);

        // 3: FIFO full for five cycles mid-packet
        do_reset();
        len[0] = 4;
        en = 4'b0001;
        cyc(2);
        fifo_full = 1'b1;
        cyc(5);
        chk("t3_no_write", 32'(wlog.size()), 32'd1);
        fifo_full = 1'b0;
        cyc(3);
        chk_log("t3_full", 4, 64'h00_01_02_03);

        // 4: grant holder stalls for three cycles with another request pending
        do_reset();
        len[0] = 4;
        en = 4'b0011;
        cyc(2);
        hold[0] = 1'b1;
        cyc(3);
        chk("t4_busy", 32'(busy),        32'd1);
        chk("t4_gnt",  32'(gnt_id),      32'd0);
        chk("t4_cnt",  32'(wlog.size()), 32'd1);
        hold[0] = 1'b0;
        cyc(4);
        chk_log("t4_stall", 5, 64'h00_01_02_03_40);

        // 5: clr during beat 2 of 4; req0 must beat req3 afterwards
        do_reset();
        len[2] = 4;
        en = 4'b0100;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        len[0] = 4; len[3] = 4;
        en = 4'b1001;
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        cyc(2);
        chk("t5_gnt", 32'(gnt_id), 32'd0);
        chk_log("t5_clr", 3, 64'h80_81_00);

        // 6: almost-full raised across a packet boundary
        do_reset();
        len[0] = 2; len[1] = 2;
        en = 4'b0011;
        cyc(2);
        fifo_afull = 1'b1;
        cyc(1);
`ifdef ARB_AFULL_GATE_EN
        chk("t6_busy", 32'(busy), 32'd0);
`else
        chk("t6_busy", 32'(busy), 32'd1);
`endif
        cyc(3);
        fifo_afull = 1'b0;
        cyc(3);
`ifdef ARB_AFULL_GATE_EN
        chk_log("t6_gate", 4, 64'h00_01_40_41);
`else
        chk_log("t6_gate", 8, 64'h00_01_40_41_02_03_42_43);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
